// File: rtl/spi_pkg.sv
// Shared definitions for the SPI write controller and the 5-register peripheral it drives.
package spi_pkg;

  localparam int FRAME_W  = 16;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int NUM_REGS = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_write_controller.sv
// SPI mode-0 master emitting 16-bit {rw, addr, data} write frames MSB-first.
// All SPI pins come straight from flops; ready/busy decode from the state.
module spi_write_controller
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int CS_GAP      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              copi,
  output logic              ncs
);

  localparam int PH_MAX = max2(max2(HALF_PERIOD, CS_SETUP), max2(CS_HOLD, CS_GAP)) - 1;
  localparam int PH_W   = (PH_MAX < 1) ? 1 : $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(CS_HOLD - 1);
  // The IDLE cycle that precedes the next acceptance completes the gap,
  // so ncs stays high exactly CS_GAP cycles between back-to-back frames.
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(CS_GAP - 2);

  spi_state_e            state;
  logic [PH_W-1:0]       ph_cnt;
  logic [3:0]            bit_cnt;
  // Bit 15 goes straight to copi on acceptance; only the remaining 15 bits are held.
  logic [FRAME_W-2:0]    sreg;
  logic                  ph_last;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    ph_last = 1'b0;
    case (state)
      ST_SETUP: ph_last = (ph_cnt == SETUP_LAST);
      ST_LOW:   ph_last = (ph_cnt == HALF_LAST);
      ST_HIGH:  ph_last = (ph_cnt == HALF_LAST);
      ST_HOLD:  ph_last = (ph_cnt == HOLD_LAST);
      ST_GAP:   ph_last = (ph_cnt == GAP_LAST);
      default:  ph_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ph_cnt  <= '0;
      bit_cnt <= '0;
      sreg    <= '0;
      sclk    <= 1'b0;
      copi    <= 1'b0;
      ncs     <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;

      // Every state exit coincides with ph_last, so this reloads on each change.
      if (state == ST_IDLE || ph_last) ph_cnt <= '0;
      else                             ph_cnt <= ph_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            sreg  <= {cmd_addr, cmd_data};
            copi  <= cmd_rw;
            ncs   <= 1'b0;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (ph_last) state <= ST_LOW;
        end
        ST_LOW: begin
          if (ph_last) begin
            sclk  <= 1'b1;
            state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (ph_last) begin
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt != 4'd15) begin
              copi  <= sreg[FRAME_W-2];
              sreg  <= {sreg[FRAME_W-3:0], 1'b0};
              state <= ST_LOW;
            end else begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (ph_last) begin
            ncs   <= 1'b1;
            copi  <= 1'b0;
            done  <= 1'b1;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (ph_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
